tft_region_arbiter: RTL and testbench

TFT_REGION_ARBITER -- requirements
Module: tft_region_arbiter

---
 rtl/tft_region_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_tft_region_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_region_arbiter.sv
// rtl/tft_region_arbiter.sv - two-requester region arbiter feeding an 8080 TFT byte stream
module tft_region_arbiter #(
    parameter int COLS = 240,
    parameter int ROWS = 320
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  reqValid,
    input  logic [15:0] colStart,
    input  logic [15:0] colEnd,
    input  logic [17:0] rowStart,
    input  logic [17:0] rowEnd,
    output logic [1:0]  reqAck,
    output logic [1:0]  reqErr,
    input  logic [31:0] pixelData,
    input  logic [1:0]  pixelValid,
    output logic [1:0]  pixelReady,
    output logic [7:0]  byteOut,
    output logic        byteDataCmd,
    output logic        byteValid,
    input  logic        byteReady,
    output logic        busy,
    output logic        activeReq,
    output logic [1:0]  regionDone
);

    typedef enum logic [2:0] {
        IDLE, CMD_COL, PAR_COL, CMD_PAGE, PAR_PAGE, CMD_WR, PIXELS, FINISH
    } state_t;

    state_t      state, nextState;
    logic        lastGrant;
    logic [7:0]  rColStart, rColEnd;
    logic [8:0]  rRowStart, rRowEnd;
    logic [16:0] pixRemain;
    logic [15:0] holdReg;
    logic        holdFull;
    logic        byteSel;
    logic [1:0]  parIdx;

    logic        grantIdx;
    logic [7:0]  selColStart, selColEnd;
    logic [8:0]  selRowStart, selRowEnd;
    logic        reqBad;
    logic [8:0]  colSpan;
    logic [9:0]  rowSpan;
    logic [16:0] pixTotal;
    logic [8:0]  parStart, parEnd;
    logic [7:0]  parByte;
    logic        canTake;
    logic        activeValid;
    logic [15:0] activePix;
    logic        xfer;

    // Round-robin pick, region selection, validity check and pixel count for the candidate grant
    always_comb begin
        grantIdx = 1'b0;
        if (reqValid == 2'b11)
            grantIdx = ~lastGrant;
        else
            grantIdx = reqValid[1];
        selColStart = grantIdx ? colStart[15:8] : colStart[7:0];
        selColEnd   = grantIdx ? colEnd[15:8]   : colEnd[7:0];
        selRowStart = grantIdx ? rowStart[17:9] : rowStart[8:0];
        selRowEnd   = grantIdx ? rowEnd[17:9]   : rowEnd[8:0];
        reqBad = (selColStart > selColEnd) || (selRowStart > selRowEnd) ||
                 (32'(selColEnd) >= COLS) || (32'(selRowEnd) >= ROWS);
        colSpan  = {1'b0, selColEnd} - {1'b0, selColStart} + 9'd1;
        rowSpan  = {1'b0, selRowEnd} - {1'b0, selRowStart} + 10'd1;
        pixTotal = 17'(colSpan) * 17'(rowSpan);
    end

    // Parameter byte for the column/page address phases: start hi, start lo, end hi, end lo
    always_comb begin
        parStart = (state == PAR_COL) ? {1'b0, rColStart} : rRowStart;
        parEnd   = (state == PAR_COL) ? {1'b0, rColEnd}   : rRowEnd;
        case (parIdx)
            2'd0:    parByte = {7'b0, parStart[8]};
            2'd1:    parByte = parStart[7:0];
            2'd2:    parByte = {7'b0, parEnd[8]};
            default: parByte = parEnd[7:0];
        endcase
        activeValid = activeReq ? pixelValid[1] : pixelValid[0];
        activePix   = activeReq ? pixelData[31:16] : pixelData[15:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state and byte-stream outputs; the holding register may refill while its low byte leaves
    always_comb begin
        nextState   = state;
        byteValid   = 1'b0;
        byteOut     = 8'h00;
        byteDataCmd = 1'b0;
        pixelReady  = 2'b00;
        regionDone  = 2'b00;
        canTake     = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (|reqValid && !reqBad)
                    nextState = CMD_COL;
            end
            CMD_COL: begin
                byteValid = 1'b1;
                byteOut   = 8'h2A;
                if (byteReady)
                    nextState = PAR_COL;
            end
            PAR_COL: begin
                byteValid   = 1'b1;
                byteDataCmd = 1'b1;
                byteOut     = parByte;
                if (byteReady && parIdx == 2'd3)
                    nextState = CMD_PAGE;
            end
            CMD_PAGE: begin
                byteValid = 1'b1;
                byteOut   = 8'h2B;
                if (byteReady)
                    nextState = PAR_PAGE;
            end
            PAR_PAGE: begin
                byteValid   = 1'b1;
                byteDataCmd = 1'b1;
                byteOut     = parByte;
                if (byteReady && parIdx == 2'd3)
                    nextState = CMD_WR;
            end
            CMD_WR: begin
                byteValid = 1'b1;
                byteOut   = 8'h2C;
                if (byteReady)
                    nextState = PIXELS;
            end
            PIXELS: begin
                byteValid   = holdFull;
                byteDataCmd = holdFull;
                byteOut     = holdFull ? (byteSel ? holdReg[7:0] : holdReg[15:8]) : 8'h00;
                canTake     = (pixRemain != 17'd0) && (!holdFull || (byteSel && byteReady));
                pixelReady[activeReq] = canTake;
                if (holdFull && byteSel && byteReady && pixRemain == 17'd0)
                    nextState = FINISH;
            end
            FINISH: begin
                regionDone[activeReq] = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign xfer = byteValid & byteReady;

    // Grant bookkeeping, region latch, parameter index and pixel holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            reqAck    <= 2'b00;
            reqErr    <= 2'b00;
            lastGrant <= 1'b1;
            activeReq <= 1'b0;
            rColStart <= 8'd0;
            rColEnd   <= 8'd0;
            rRowStart <= 9'd0;
            rRowEnd   <= 9'd0;
            pixRemain <= 17'd0;
            holdReg   <= 16'd0;
            holdFull  <= 1'b0;
            byteSel   <= 1'b0;
            parIdx    <= 2'd0;
        end else begin
            reqAck <= 2'b00;
            reqErr <= 2'b00;
            if (state == IDLE && |reqValid) begin
                lastGrant        <= grantIdx;
                reqAck[grantIdx] <= 1'b1;
                reqErr[grantIdx] <= reqBad;
                if (!reqBad) begin
                    activeReq <= grantIdx;
                    rColStart <= selColStart;
                    rColEnd   <= selColEnd;
                    rRowStart <= selRowStart;
                    rRowEnd   <= selRowEnd;
                    pixRemain <= pixTotal;
                    parIdx    <= 2'd0;
                end
            end
            if ((state == PAR_COL || state == PAR_PAGE) && xfer)
                parIdx <= parIdx + 2'd1;
            if (state == PIXELS) begin
                if (xfer) begin
                    if (byteSel) begin
                        holdFull <= 1'b0;
                        byteSel  <= 1'b0;
                    end else begin
                        byteSel <= 1'b1;
                    end
                end
                if (canTake && activeValid) begin
                    holdReg   <= activePix;
                    holdFull  <= 1'b1;
                    byteSel   <= 1'b0;
                    pixRemain <= pixRemain - 17'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tft_region_arbiter.sv
// tb/tb_tft_region_arbiter.sv - self-checking bench for tft_region_arbiter
module tb_tft_region_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  reqValid = 2'b00;
    logic [15:0] colStart = '0, colEnd = '0;
    logic [17:0] rowStart = '0, rowEnd = '0;
    logic [1:0]  reqAck, reqErr;
    logic [31:0] pixelData = '0;
    logic [1:0]  pixelValid = 2'b00;
    logic [1:0]  pixelReady;
    logic [7:0]  byteOut;
    logic        byteDataCmd, byteValid;
    logic        byteReady = 1'b1;
    logic        busy, activeReq;
    logic [1:0]  regionDone;

    tft_region_arbiter #(.COLS(240), .ROWS(320)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid),
        .colStart(colStart), .colEnd(colEnd), .rowStart(rowStart), .rowEnd(rowEnd),
        .reqAck(reqAck), .reqErr(reqErr), .pixelData(pixelData), .pixelValid(pixelValid),
        .pixelReady(pixelReady), .byteOut(byteOut), .byteDataCmd(byteDataCmd),
        .byteValid(byteValid), .byteReady(byteReady), .busy(busy),
        .activeReq(activeReq), .regionDone(regionDone)
    );

    always #5 clk = ~clk;

    int nAssert = 0, nFail = 0;
    logic [8:0]  expQ[$];
    logic [15:0] pixQ0[$], pixQ1[$];
    int ackCnt[2] = '{0, 0}, errCnt[2] = '{0, 0}, rdCnt[2] = '{0, 0};
    int expAck[2] = '{0, 0}, expErr[2] = '{0, 0}, expDone[2] = '{0, 0};
    int gotBytes = 0;
    bit stallMode = 0, gapMode = 0;
    bit stallPrev = 0;
    logic [8:0] prevWord = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the byte sequence a region must produce, and the pixels fed for it
    task automatic addRegion(input int i, input int cs, input int ce, input int rs, input int re,
                             input logic [15:0] seed);
        int n;
        logic [15:0] p;
        expQ.push_back({1'b0, 8'h2A});
        expQ.push_back({1'b1, 8'(cs / 256)}); expQ.push_back({1'b1, 8'(cs % 256)});
        expQ.push_back({1'b1, 8'(ce / 256)}); expQ.push_back({1'b1, 8'(ce % 256)});
        expQ.push_back({1'b0, 8'h2B});
        expQ.push_back({1'b1, 8'(rs / 256)}); expQ.push_back({1'b1, 8'(rs % 256)});
        expQ.push_back({1'b1, 8'(re / 256)}); expQ.push_back({1'b1, 8'(re % 256)});
        expQ.push_back({1'b0, 8'h2C});
        n = (ce - cs + 1) * (re - rs + 1);
        for (int k = 0; k < n; k++) begin
            p = seed + 16'(k * 37);
            if (i == 0) pixQ0.push_back(p); else pixQ1.push_back(p);
            expQ.push_back({1'b1, p[15:8]});
            expQ.push_back({1'b1, p[7:0]});
        end
    endtask

    task automatic setRegion(input int i, input int cs, input int ce, input int rs, input int re);
        colStart[i*8 +: 8] = 8'(cs);
        colEnd[i*8 +: 8]   = 8'(ce);
        rowStart[i*9 +: 9] = 9'(rs);
        rowEnd[i*9 +: 9]   = 9'(re);
    endtask

    // Compare process: byte stream against model, stall stability, per-cycle handshake rules
    always @(negedge clk) begin
        if (reset) begin
            stallPrev = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (reqAck[i]) ackCnt[i]++;
                if (reqErr[i]) begin
                    errCnt[i]++;
                    check($sformatf("err_with_ack%0d", i), 32'(reqAck[i]), 32'd1);
                end
                if (regionDone[i]) rdCnt[i]++;
            end
            if (!busy) check("idle_no_valid", 32'(byteValid), 32'd0);
            if (|pixelReady) check("pixready_granted_only", 32'(pixelReady), activeReq ? 32'd2 : 32'd1);
            if (stallPrev) begin
                check("stall_valid", 32'(byteValid), 32'd1);
                check("stall_byte", 32'({byteDataCmd, byteOut}), 32'(prevWord));
            end
            if (byteValid && byteReady) begin
                gotBytes++;
                if (expQ.size() == 0) begin
                    nAssert++; nFail++;
                    $display("FAIL unexpected_byte: got %0h expected none", {byteDataCmd, byteOut});
                end else begin
                    check("byte", 32'({byteDataCmd, byteOut}), 32'(expQ.pop_front()));
                end
            end
            stallPrev = byteValid && !byteReady;
            prevWord  = {byteDataCmd, byteOut};
        end
    end

    // Source driver: pixel queues, junk on idle lanes, optional stalls and gaps
    bit acc0, acc1;
    always begin
        @(negedge clk);
        acc0 = !reset && pixelValid[0] && pixelReady[0];
        acc1 = !reset && pixelValid[1] && pixelReady[1];
        @(posedge clk);
        #1;
        if (acc0 && pixQ0.size() > 0) void'(pixQ0.pop_front());
        if (acc1 && pixQ1.size() > 0) void'(pixQ1.pop_front());
        byteReady = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pixQ0.size() > 0) begin
            pixelValid[0] = gapMode ? 1'($urandom_range(0, 1)) : 1'b1;
            pixelData[15:0] = pixQ0[0];
        end else begin
            pixelValid[0] = 1'b1;
            pixelData[15:0] = 16'hDEAD;
        end
        if (pixQ1.size() > 0) begin
            pixelValid[1] = gapMode ? 1'($urandom_range(0, 1)) : 1'b1;
            pixelData[31:16] = pixQ1[0];
        end else begin
            pixelValid[1] = 1'b1;
            pixelData[31:16] = 16'hDEAD;
        end
    end

    task automatic grantCheck(input int i, input bit bad);
        check($sformatf("ack%0d", i), 32'(reqAck), (i == 1) ? 32'd2 : 32'd1);
        check($sformatf("err%0d", i), 32'(reqErr), bad ? ((i == 1) ? 32'd2 : 32'd1) : 32'd0);
        check("busy_at_ack", 32'(busy), bad ? 32'd0 : 32'd1);
        check("valid_at_ack", 32'(byteValid), bad ? 32'd0 : 32'd1);
        if (!bad) begin
            check("first_byte_2A", 32'({byteDataCmd, byteOut}), 32'h02A);
            check("activeReq_at_ack", 32'(activeReq), 32'(i));
        end
    endtask

    task automatic pulseReq(input int i, input bit bad);
        @(posedge clk); #1 reqValid[i] = 1'b1;
        @(posedge clk); #1 reqValid[i] = 1'b0;
        @(negedge clk);
        grantCheck(i, bad);
        expAck[i]++;
        if (bad) expErr[i]++; else expDone[i]++;
        @(negedge clk);
        check("ack_one_cycle", 32'(reqAck), 32'd0);
    endtask

    task automatic waitDone(input int i);
        int t;
        t = 0;
        while (rdCnt[i] < expDone[i] && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("done_reached%0d", i), 32'(rdCnt[i] >= expDone[i]), 32'd1);
        repeat (3) @(negedge clk);
        check("model_drained", 32'(expQ.size()), 32'd0);
    endtask

    task automatic dualReq(input int first);
        int other, t;
        other = 1 - first;
        @(posedge clk); #1 reqValid = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        grantCheck(first, 0);
        expAck[first]++; expDone[first]++;
        @(posedge clk); #1 reqValid[first] = 1'b0;
        t = 0;
        while (!reqAck[other] && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("second_grant_seen", 32'(reqAck[other]), 32'd1);
        check("first_done_before_second", 32'(rdCnt[first]), 32'(expDone[first]));
        check("second_activeReq", 32'(activeReq), 32'(other));
        expAck[other]++; expDone[other]++;
        @(posedge clk); #1 reqValid[other] = 1'b0;
        waitDone(other);
    endtask

    logic [8:0] lit038[13] = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h105, 9'h02B,
                               9'h100, 9'h107, 9'h100, 9'h107, 9'h02C, 9'h1AB, 9'h1CD};
    logic [8:0] litHdr[11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02B,
                               9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};

    initial begin
        int base, t, rdSave;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_byteValid", 32'(byteValid), 32'd0);
        check("rst_byteOut", 32'(byteOut), 32'd0);
        check("rst_dataCmd", 32'(byteDataCmd), 32'd0);
        check("rst_reqAck", 32'(reqAck), 32'd0);
        check("rst_reqErr", 32'(reqErr), 32'd0);
        check("rst_pixelReady", 32'(pixelReady), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_activeReq", 32'(activeReq), 32'd0);
        check("rst_regionDone", 32'(regionDone), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Simultaneous requests after reset: req0 first (col edge 239), then req1 (row edge 319)
        setRegion(0, 0, 239, 0, 0);
        setRegion(1, 0, 0, 0, 319);
        addRegion(0, 0, 239, 0, 0, 16'h1000);
        addRegion(1, 0, 0, 0, 319, 16'h2000);
        dualReq(0);

        // Single-pixel region on req1
        setRegion(1, 5, 5, 7, 7);
        addRegion(1, 5, 5, 7, 7, 16'hABCD);
        for (int k = 0; k < 13; k++) check("model_038", 32'(expQ[k]), 32'(lit038[k]));
        pulseReq(1, 0);
        waitDone(1);

        // Rejected regions on req0
        for (int v = 0; v < 4; v++) begin
            case (v)
                0: setRegion(0, 10, 9, 0, 0);
                1: setRegion(0, 0, 240, 0, 0);
                2: setRegion(0, 0, 0, 0, 320);
                default: setRegion(0, 0, 0, 5, 4);
            endcase
            pulseReq(0, 1);
            repeat (3) @(negedge clk);
            check("reject_not_busy", 32'(busy), 32'd0);
        end

        // A rejection still counts as the latest grant: req1 wins the next tie
        setRegion(1, 1, 2, 1, 1);
        setRegion(0, 3, 3, 2, 3);
        addRegion(1, 1, 2, 1, 1, 16'h3000);
        addRegion(0, 3, 3, 2, 3, 16'h4000);
        dualReq(1);

        // 4x3 region under random byte stalls and pixel gaps
        stallMode = 1; gapMode = 1;
        setRegion(0, 2, 5, 1, 3);
        addRegion(0, 2, 5, 1, 3, 16'h1234);
        base = gotBytes;
        pulseReq(0, 0);
        waitDone(0);
        check("stall_byte_count", 32'(gotBytes - base), 32'd35);
        stallMode = 0; gapMode = 0;
        @(posedge clk); #1;

        // Full panel header, then reset in the middle of the pixel phase
        setRegion(0, 0, 239, 0, 319);
        addRegion(0, 0, 239, 0, 319, 16'h0F0F);
        for (int k = 0; k < 11; k++) check("model_hdr", 32'(expQ[k]), 32'(litHdr[k]));
        base = gotBytes;
        pulseReq(0, 0);
        expDone[0]--;
        t = 0;
        while (gotBytes - base < 611 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("panel_progress", 32'(gotBytes - base >= 611), 32'd1);
        check("panel_busy", 32'(busy), 32'd1);
        rdSave = rdCnt[0];
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(byteValid), 32'd0);
        check("midrst_done", 32'(regionDone), 32'd0);
        expQ.delete(); pixQ0.delete(); pixQ1.delete();
        repeat (3) @(negedge clk);
        check("midrst_no_done", 32'(rdCnt[0]), 32'(rdSave));
        setRegion(1, 0, 1, 0, 0);
        addRegion(1, 0, 1, 0, 0, 16'h5A5A);
        pulseReq(1, 0);
        waitDone(1);

        for (int i = 0; i < 2; i++) begin
            check($sformatf("ack_total%0d", i), 32'(ackCnt[i]), 32'(expAck[i]));
            check($sformatf("err_total%0d", i), 32'(errCnt[i]), 32'(expErr[i]));
            check($sformatf("done_total%0d", i), 32'(rdCnt[i]), 32'(expDone[i]));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
